// File: rtl/bram_ctrl_pkg.sv
// Shared constants for the BRAM port controller: data width, FSM encoding, master indices.
package bram_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter2.sv
// Two-way combinational pick: forced hand-over, then lock owner, then round-robin.
module rr_arbiter2
  import bram_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       lock_active_i,
  input  logic       lock_owner_i,
  input  logic       force_other_i,
  output logic [1:0] grant_o
);

  logic other;

  always_comb begin
    grant_o = 2'b00;
    other   = ~lock_owner_i;
    if (force_other_i && req_i[other]) begin
      grant_o[other] = 1'b1;
    end else if (lock_active_i && req_i[lock_owner_i]) begin
      grant_o[lock_owner_i] = 1'b1;
    end else if (req_i == 2'b11) begin
      // Tie goes to whoever was not served last.
      grant_o[~last_grant_i] = 1'b1;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two masters with round-robin, bounded lock and optional zero-fill.
module bram_port_arbiter
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned MAX_LOCK       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  init_busy
);

  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  lock_active_q, lock_active_d;
  logic                  lock_owner_q, lock_owner_d;
  logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [1:0]            rvalid_q;

  logic [1:0] req;
  logic [1:0] grant;
  logic       owner_lock;
  logic       lock_hold;
  logic       force_other;
  logic       gidx;
  logic       g_lock;

  // Requests only compete while arbitrating and out of reset.
  assign req         = (state_q == ST_ARB && !reset) ? {m1_req, m0_req} : 2'b00;
  assign owner_lock  = lock_owner_q ? m1_lock : m0_lock;
  assign lock_hold   = lock_active_q & owner_lock;
  assign force_other = lock_hold & (lock_cnt_q == LOCK_W'(MAX_LOCK)) & req[~lock_owner_q];
  assign gidx        = grant[1];
  assign g_lock      = gidx ? m1_lock : m0_lock;

  rr_arbiter2 u_arb (
    .req_i         (req),
    .last_grant_i  (last_grant_q),
    .lock_active_i (lock_hold),
    .lock_owner_i  (lock_owner_q),
    .force_other_i (force_other),
    .grant_o       (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
      clr_cnt_q     <= '0;
      last_grant_q  <= M1;
      lock_active_q <= 1'b0;
      lock_owner_q  <= M0;
      lock_cnt_q    <= '0;
      rvalid_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      last_grant_q  <= last_grant_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      rvalid_q      <= grant;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    last_grant_d  = last_grant_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = lock_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d   = ST_ARB;
        clr_cnt_d = '0;
      end
    end else if (grant == 2'b00) begin
      lock_active_d = 1'b0;
      lock_cnt_d    = '0;
    end else begin
      last_grant_d = gidx;
      // Owner continues its run; a forced hand-over or fresh grant re-evaluates ownership.
      if (lock_hold && !force_other && gidx == lock_owner_q) begin
        lock_cnt_d = (lock_cnt_q == LOCK_W'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
      end else if (g_lock) begin
        lock_active_d = 1'b1;
        lock_owner_d  = gidx;
        lock_cnt_d    = LOCK_W'(1);
      end else begin
        lock_active_d = 1'b0;
        lock_cnt_d    = '0;
      end
    end
  end

  // BRAM port mux: clear sequencer, else the granted master.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        bram_en   = 1'b1;
        bram_we   = 1'b1;
        bram_addr = clr_cnt_q;
      end else if (grant[0]) begin
        bram_en   = 1'b1;
        bram_we   = m0_we;
        bram_addr = m0_addr;
        bram_din  = m0_wdata;
      end else if (grant[1]) begin
        bram_en   = 1'b1;
        bram_we   = m1_we;
        bram_addr = m1_addr;
        bram_din  = m1_wdata;
      end
    end
  end

  assign m0_gnt    = grant[0];
  assign m1_gnt    = grant[1];
  assign m0_rvalid = rvalid_q[0] & ~reset;
  assign m1_rvalid = rvalid_q[1] & ~reset;
  assign m0_rdata  = bram_dout;
  assign m1_rdata  = bram_dout;
  assign init_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: BRAM models, response scoreboard, clear/contention/lock/reset scenarios.
module tb_bram_port_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bram_en, bram_we, init_busy;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;

  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata;
  logic          b_bram_en, b_bram_we, b_init_busy;
  logic [AW-1:0] b_bram_addr;
  logic [DW-1:0] b_bram_din, b_bram_dout;

  logic [DW-1:0] ram_a [0:(1<<AW)-1];
  logic [DW-1:0] ram_b [0:(1<<AW)-1];
  logic [DW-1:0] sb_mem [0:(1<<AW)-1];

  typedef struct packed {
    logic          m;
    logic [DW-1:0] d;
  } rsp_t;
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .init_busy(init_busy)
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0), .MAX_LOCK(4)) dut_nc (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_addr(b_bram_addr), .bram_din(b_bram_din),
    .bram_dout(b_bram_dout), .init_busy(b_init_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous write-first BRAM models.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        ram_a[bram_addr] <= bram_din;
        bram_dout        <= bram_din;
      end else begin
        bram_dout <= ram_a[bram_addr];
      end
    end
    if (b_bram_en) begin
      if (b_bram_we) begin
        ram_b[b_bram_addr] <= b_bram_din;
        b_bram_dout        <= b_bram_din;
      end else begin
        b_bram_dout <= ram_b[b_bram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Scoreboard: push on grant, pop one cycle later against rvalid/rdata.
  always @(negedge clk) begin : mon
    rsp_t          e;
    logic          m;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (reset) begin
      exp_q.delete();
      chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'({m1_rvalid, m0_rvalid}), e.m ? 32'd2 : 32'd1);
        chk("rsp_data", 32'(e.m ? m1_rdata : m0_rdata), 32'(e.d));
      end else begin
        chk("no_rsp", 32'({m1_rvalid, m0_rvalid}), 32'd0);
      end
      if (m0_gnt || m1_gnt) begin
        chk("onehot", 32'(m0_gnt & m1_gnt), 32'd0);
        m  = m1_gnt;
        we = m ? m1_we : m0_we;
        a  = m ? m1_addr : m0_addr;
        d  = m ? m1_wdata : m0_wdata;
        chk("bram_bus", 32'({bram_en, bram_we, bram_addr}), 32'({1'b1, we, a}));
        if (we) begin
          chk("bram_din", 32'(bram_din), 32'(d));
          sb_mem[a] = d;
        end else begin
          d = sb_mem[a];
        end
        exp_q.push_back('{m: m, d: d});
      end
    end
  end

  task automatic do_access(input logic m, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat);
    if (!m) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    lat = -1;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (m ? m1_gnt : m0_gnt) begin lat = n; break; end
    end
    if (lat < 0) chk("acc_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!m) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int         lat;
    logic [1:0] g, exp_g;
    logic [9:0] lock_pat;
    int         n0, n1;
    reset = 1'b1;
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_a[i] = 16'hA5A5; ram_b[i] = 16'h5A5A; sb_mem[i] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'({m1_gnt, m0_gnt, bram_en, bram_we, m1_rvalid, m0_rvalid, init_busy}), 32'd1);
    chk("reset_nc_busy", 32'(b_init_busy), 32'd0);

    // Zero-fill sweep with m0 already asking for the top word.
    @(posedge clk); #1;
    reset = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h1FF;
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      chk("clear", 32'({m1_gnt, m0_gnt, bram_en, bram_we, init_busy, bram_addr, bram_din}),
          32'({2'b00, 3'b111, 9'(i), 16'h0000}));
    end
    @(negedge clk);
    chk("clear_done", 32'({init_busy, m1_gnt, m0_gnt}), 32'b001);
    @(posedge clk); #1; m0_req = 1'b0;
    tick(2);

    do_access(1'b0, 1'b1, 9'h010, 16'hBEEF, lat);
    chk("wr_lat", 32'(lat), 32'd0);
    do_access(1'b0, 1'b0, 9'h010, 16'h0000, lat);
    chk("rd_lat", 32'(lat), 32'd0);
    tick(2);

    // Contention without lock: m0 was served last, so m1 leads and grants alternate.
    n0 = 0; n1 = 0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h020; m0_wdata = 16'h1000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h020;
    exp_g = 2'b10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      g = {m1_gnt, m0_gnt};
      chk("rr_alt", 32'(g), 32'(exp_g));
      exp_g = {exp_g[0], exp_g[1]};
      @(posedge clk); #1;
      if (g[0]) begin n0++; m0_addr = 9'(9'h020 + n0); m0_wdata = 16'(16'h1000 + n0); end
      if (g[1]) begin n1++; m1_addr = 9'(9'h020 + n1); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(2);

    // Lock fairness with MAX_LOCK=4: m0 alone first, m1 joins on the next cycle.
    lock_pat = 10'b1000010000;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b1; m0_addr = 9'h010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("lock_gnt", 32'({m1_gnt, m0_gnt}), lock_pat[k] ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h011;
    end
    m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0;
    tick(2);

    // Reset in the middle of the clear sweep restarts it from address 0.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h100;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("clear1", 32'({m1_gnt, m0_gnt, bram_en, bram_we, init_busy, bram_addr}),
          32'({2'b00, 3'b111, 9'(i)}));
    end
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("midrst_quiet", 32'({m1_gnt, m0_gnt, bram_en, bram_we}), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      chk("clear2", 32'({m1_gnt, m0_gnt, bram_en, bram_we, init_busy, bram_addr}),
          32'({2'b00, 3'b111, 9'(i)}));
    end
    @(negedge clk);
    chk("clear2_done", 32'({init_busy, m1_gnt, m0_gnt}), 32'b010);

    // Reset the cycle after m1's grant: its response is dropped.
    @(posedge clk); #1;
    reset = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h000;
    @(negedge clk);
    chk("inflight_drop", 32'(m1_rvalid), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("nc_first_tie", 32'({b_m1_gnt, b_m0_gnt}), 32'b01);
    chk("nc_busy", 32'(b_init_busy), 32'd0);
    chk("clr_hold", 32'({init_busy, m1_gnt, m0_gnt}), 32'b100);
    @(posedge clk); #1; m0_req = 1'b0; m1_req = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Shares one port of the 16-bit true dual-port BRAM between two requesters (m0: CPU load/store, m1: loader/DMA) using round-robin arbitration, a bounded lock/burst mode and a one-cycle response path. After reset it can optionally run a clear sequencer that zero-fills the whole memory before granting any requester. The block sits between the requesters and a single BRAM port (en/we/addr/din/dout).

Parameters:
ADDR_WIDTH, 9, BRAM address width (DEPTH = 2^ADDR_WIDTH = 512)
CLEAR_ON_RESET, 1, 1 = zero-fill all addresses after reset; 0 = go straight to arbitration
MAX_LOCK, 16, maximum consecutive locked grants to one master while the other master is waiting

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  m0 access request; hold we/addr/wdata stable until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  request to keep ownership across consecutive accesses
m0_addr  in  ADDR_WIDTH  word address
m0_wdata  in  16  write data
m0_gnt  out  1  access accepted this cycle (combinational)
m0_rvalid  out  1  response valid, exactly 1 cycle after m0_gnt
m0_rdata  out  16  response data (BRAM dout passthrough)
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0
bram_en  out  1  BRAM port enable
bram_we  out  1  BRAM port write enable
bram_addr  out  ADDR_WIDTH  BRAM port address
bram_din  out  16  BRAM port write data
bram_dout  in  16  BRAM port read data (synchronous, write-first)
init_busy  out  1  clear sequence in progress

Behaviour:
- FSM states: CLEAR, ARB. Reset -> CLEAR if CLEAR_ON_RESET=1, else ARB.
- CLEAR: clr_cnt runs 0..DEPTH-1, one address per cycle. bram_en=1, bram_we=1, bram_din=0, bram_addr=clr_cnt. init_busy=1. Both gnt=0. After writing DEPTH-1 -> ARB; first grant is possible in the following cycle. Duration is exactly DEPTH cycles.
- ARB: each cycle select at most one requesting master. gnt, bram_en, bram_we, bram_addr and bram_din are driven combinationally from the selected master in the same cycle. No request -> bram_en=0, bram_we=0.
- Response: rvalid_sel registered; mX_rvalid=1 exactly one cycle after mX_gnt, for reads and writes. mX_rdata = bram_dout. A write response returns the written data (write-first). Back-to-back grants give one response per cycle.
- Round-robin: last_grant register, reset value selects m1 so that m0 wins the first tie. With both masters requesting and no lock active, grant the master not in last_grant.
- Lock: if the granted master has mX_lock=1 at grant, it becomes owner (lock_active=1, lock_cnt=1). While lock_active, the owner wins every cycle it requests, and each owner grant increments lock_cnt.
- Lock fairness: if lock_cnt == MAX_LOCK and the other master is requesting, grant the other master once, clear lock_active and lock_cnt, and ignore the owner's lock for that cycle. The other master gets no lock credit from that forced grant unless its own lock=1.
- Lock release: lock_active clears in any cycle the owner's lock=0, or the owner is not requesting.
- Reset during CLEAR or mid-traffic: the clear restarts at address 0. In-flight rvalid is dropped (rvalid=0 the next cycle). Lock state, last_grant and counters return to reset values.
- Reset values: mX_gnt=0, mX_rvalid=0, lock_active=0, lock_cnt=0, clr_cnt=0. init_busy=1 if CLEAR_ON_RESET else 0. While reset is high, BRAM outputs are en=0, we=0.
- Widths: clr_cnt is ADDR_WIDTH bits and its terminal count is compared, not wrapped. lock_cnt is $clog2(MAX_LOCK+1) bits and saturates at MAX_LOCK.

Decomposition:
- Shared package bram_ctrl_pkg: DATA_WIDTH=16, FSM state encoding (ST_CLEAR, ST_ARB), master index constants (M0=0, M1=1).
- One sub-module rr_arbiter2: inputs req[1:0], last_grant, lock_active, lock_owner, force_other; output one-hot grant[1:0]. Purely combinational pick.
- FSM, counters and response registers stay in the top module.

Test Plan:
- Clear sequence, CLEAR_ON_RESET=1: release reset -> bram_we=1 with addr 0..511 over 512 cycles, init_busy falls. Then m0 reads 0x1FF -> m0_rvalid next cycle with rdata=0x0000.
- Single write/read: m0 writes 0xBEEF to 0x010 -> gnt same cycle, rvalid+1 with rdata=0xBEEF. m0 reads 0x010 -> rvalid+1 with rdata=0xBEEF.
- Contention: m0 and m1 both request continuously without lock -> grants alternate m0, m1, m0, m1. Each rvalid goes to the correct master one cycle later.
- Lock fairness, MAX_LOCK=4: m0 locked and requesting continuously, m1 requesting -> m0 granted 4 cycles, m1 granted on the 5th, then m0 may re-lock.
- Reset mid-clear: assert reset at clr_cnt=200 for 1 cycle -> clear restarts at addr 0, total 512 more cycles, no gnt during clear.
- Reset with response in flight: m1 read granted, reset asserted next cycle -> m1_rvalid=0. After reset, with CLEAR_ON_RESET=0, the first tie goes to m0.
